// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: default widths, memory
// read/write select encodings and the buffered store entry.
package store_buffer_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned DW_DEF    = 8;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Execute-side load/store handshakes plus the data-memory port of the store buffer.
// master = execute stage and memory; slave = store_buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) ();

    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;

    logic [AW-1:0] mem_read_addr;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_acc;
    logic          mem_ren_wen;
    logic [DW-1:0] mem_rdata;

    logic          sb_empty;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        input  st_ready, ld_ready, ld_rvalid, ld_rdata,
        input  mem_read_addr, mem_write_addr, mem_acc, mem_ren_wen, sb_empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        output st_ready, ld_ready, ld_rvalid, ld_rdata,
        output mem_read_addr, mem_write_addr, mem_acc, mem_ren_wen, sb_empty
    );

endinterface

// File: rtl/store_buffer_sb_fifo.sv
// Store-entry FIFO: storage, wrapping pointers and occupancy count, with the whole
// storage array exported so the owner can scan buffered stores.
module sb_fifo
  import store_buffer_pkg::*;
#(
    parameter int unsigned Depth = DEPTH_DEF,
    parameter type         entry_t = sb_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output entry_t [Depth-1:0]           entries_o,
    output logic [$clog2(Depth)-1:0]     wr_ptr_o,
    output logic [$clog2(Depth):0]       count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    entry_t [Depth-1:0] mem_q;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]      count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);

    // A full buffer refuses a push even while the head is draining.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign wr_ptr_o  = wr_ptr_q;
    assign count_o   = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between execute and the data memory: queues stores, drains them when
// no load owns the port. STORE_BUFFER_FWD_EN enables store-to-load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    store_buffer_if.slave   bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t             st_entry, head;
    entry_t [DEPTH-1:0] entries;
    logic [PtrW-1:0]    wr_ptr;
    logic [PtrW:0]      count;
    logic               full, empty;
    logic               ld_fire, drain;
    logic               ld_rvalid_q;
    logic [DW-1:0]      ld_rdata_q, ld_rdata_d;

    assign st_entry = '{addr: bus.st_addr, data: bus.st_data};

    sb_fifo #(
        .Depth   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (bus.st_valid),
        .push_data_i (st_entry),
        .pop_i       (drain),
        .head_o      (head),
        .entries_o   (entries),
        .wr_ptr_o    (wr_ptr),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign bus.st_ready = !full;
    assign bus.sb_empty = empty;

`ifdef STORE_BUFFER_FWD_EN
    assign bus.ld_ready = 1'b1;

    // Walk oldest to youngest so the youngest matching store is the one left standing.
    always_comb begin
        logic [PtrW-1:0] idx;
        idx        = '0;
        ld_rdata_d = bus.mem_rdata;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = wr_ptr - PtrW'(i) - PtrW'(1);
            if (((PtrW+1)'(i) < count) && (entries[idx].addr == bus.ld_addr)) begin
                ld_rdata_d = entries[idx].data;
            end
        end
    end
`else
    // Loads wait for an empty buffer, so memory always holds the latest value.
    assign bus.ld_ready = empty;
    assign ld_rdata_d   = bus.mem_rdata;

    logic unused_fwd;
    assign unused_fwd = ^{entries, wr_ptr, count};
`endif

    assign ld_fire = bus.ld_valid && bus.ld_ready;
    assign drain   = !ld_fire && !empty;

    always_comb begin
        bus.mem_ren_wen    = drain ? MEM_WRITE : MEM_READ;
        bus.mem_read_addr  = bus.ld_addr;
        bus.mem_write_addr = head.addr;
        bus.mem_acc        = head.data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_rvalid_q <= 1'b0;
            ld_rdata_q  <= '0;
        end else begin
            ld_rvalid_q <= ld_fire;
            if (ld_fire) ld_rdata_q <= ld_rdata_d;
        end
    end

    assign bus.ld_rvalid = ld_rvalid_q;
    assign bus.ld_rdata  = ld_rdata_q;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Load/store front-end between the execute/accumulator stage and the 256x8 data memory.
- Queues accumulator stores in a small FIFO and drains them to memory when memory is idle.
- Serves loads with priority over draining, and returns load data registered.
- Drives the memory's single read/write select: 0 = read, 1 = write.

Parameters:
- DEPTH, 4, store entries; power of 2, minimum 2.
- AW, 8, address width.
- DW, 8, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request from execute.
- st_ready  out  1  store accepted when st_valid & st_ready.
- st_addr  in  AW  store address.
- st_data  in  DW  store data (accumulator).
- ld_valid  in  1  load request.
- ld_ready  out  1  load accepted when ld_valid & ld_ready.
- ld_addr  in  AW  load address.
- ld_rvalid  out  1  load data valid, one-cycle pulse.
- ld_rdata  out  DW  load result.
- mem_read_addr  out  AW  to memory read address.
- mem_write_addr  out  AW  to memory write address.
- mem_acc  out  DW  to memory write data.
- mem_ren_wen  out  1  to memory: 0 = read, 1 = write.
- mem_rdata  in  DW  combinational memory read data; 0 while mem_ren_wen=1.
- sb_empty  out  1  buffer empty, used for fence/halt.

Behaviour:
- Reset (async assert, sync release): FIFO pointers and count = 0, ld_rvalid = 0, ld_rdata = 0, sb_empty = 1. Pending stores are discarded, including on reset mid-operation.
- FIFO storage: wr_ptr/rd_ptr have log2(DEPTH) bits and wrap modulo DEPTH; count has log2(DEPTH)+1 bits.
- Store accept: st_ready = (count != DEPTH). A full buffer accepts nothing, even on a drain cycle (no push-through). The entry is written at wr_ptr at the edge.
- Load accept: ld_ready = 1 (forwarding build, see Optional Feature).
- Priority per cycle: an accepted load owns the memory port. Otherwise, if count > 0, drain the head.
- Memory outputs are combinational:
  - Drain cycle: mem_ren_wen = 1, mem_write_addr/mem_acc = head entry; rd_ptr advances and count decrements at the edge.
  - Any other cycle: mem_ren_wen = 0, mem_read_addr = ld_addr; write address/data hold the head entry.
- Load result: registered. ld_rvalid = 1 in cycle N+1 for a load accepted in cycle N; ld_rdata holds until the next load returns.
- Forward path: the youngest buffered entry whose address equals ld_addr supplies ld_rdata instead of mem_rdata. Matching is comb over valid entries, qualified by count, scanned newest to oldest from wr_ptr-1.
- Same-cycle store and load to the same address: the load sees the pre-store value; the new store is not yet in the buffer.
- Simultaneous accepted store and drain: count is unchanged.
- Back-to-back loads keep the memory port and starve draining. Drain resumes on the first load-free cycle.
- sb_empty = (count == 0), combinational.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined: store-to-load forwarding as above; ld_ready = 1 always.
- Undefined: no compare logic; ld_ready = sb_empty, so loads stall until all stores have drained; ld_rdata is always mem_rdata.
- Both builds return identical architectural results.

Decomposition:
- Shared package: AW/DW defaults, the mem_ren_wen encodings MEM_READ = 0 and MEM_WRITE = 1, and a store-entry struct {addr, data}.
- Natural sub-module: sb_fifo (storage, pointers, count, full/empty, plus a read port for the forward scan). store_buffer holds the arbitration, forward mux and load return register.

Test Plan:
- Reset mid-drain: push 3 stores, assert rst_n=0 for 1 cycle -> sb_empty=1, ld_rvalid=0, no further mem_ren_wen=1 cycles.
- Fill: 4 stores, no loads, memory held off by continuous loads -> st_ready=0 after the 4th. Stop loads -> 4 write cycles, addresses in push order.
- Forward (FWD_EN): store 0x10<-0xAA then 0x10<-0x55, load 0x10 in the next cycle -> ld_rvalid the following cycle, ld_rdata=0x55, mem not written yet.
- Load priority: buffer holds 0x20<-0x11, loads every cycle for 5 cycles -> mem_ren_wen=0 throughout. First idle cycle -> mem_ren_wen=1, mem_write_addr=0x20, mem_acc=0x11.
- No FWD build: store 0x30<-0x7F, load 0x30 -> ld_ready=0 until drain; ld_rdata=0x7F from memory.
- Wrap-around: 10 store/drain pairs through DEPTH=4 -> memory contents match, count never exceeds 4.
